// File: rtl/fetch_controller_if.sv
// Fetch-side bus of fetch_controller: instruction memory port, redirect input,
// decode-facing queue head, and fault reporting.
// Handshake: a head entry transfers on any rising edge where OutValid_40 && OutReady_40;
// OutValid_40 never depends on OutReady_40, and the head stays stable until accepted
// unless a redirect flushes it.
interface fetch_controller_if;
    logic [31:0] ImemAddress_40;
    logic [31:0] ImemInstruction_40;
    logic        Redirect_40;
    logic [31:0] RedirectTarget_40;
    logic        OutValid_40;
    logic        OutReady_40;
    logic [31:0] OutInstruction_40;
    logic [31:0] OutPC_40;
    logic        Fault_40;
    logic [31:0] FaultPC_40;
    logic [0:0]  FetchState_40;

    modport master (
        output ImemAddress_40,
        input  ImemInstruction_40,
        input  Redirect_40,
        input  RedirectTarget_40,
        output OutValid_40,
        input  OutReady_40,
        output OutInstruction_40,
        output OutPC_40,
        output Fault_40,
        output FaultPC_40,
        output FetchState_40
    );

    modport slave (
        input  ImemAddress_40,
        output ImemInstruction_40,
        output Redirect_40,
        output RedirectTarget_40,
        input  OutValid_40,
        output OutReady_40,
        input  OutInstruction_40,
        input  OutPC_40,
        input  Fault_40,
        input  FaultPC_40,
        input  FetchState_40
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC register, decoupling queue toward decode,
// redirect flush, and sticky fault on misaligned or out-of-range fetch.
module fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_WORDS  = 256
) (
    input logic                 Clk_40,
    input logic                 Rst_40,
    fetch_controller_if.master  bus
);
    localparam int              PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(QUEUE_DEPTH);
    localparam logic [31:0]     IMEM_LIMIT = 32'(IMEM_WORDS);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       fault_pc_q, fault_pc_d;
    logic [31:0]       q_pc_q  [QUEUE_DEPTH];
    logic [31:0]       q_ins_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic push, pop, flush, full, slot_ok, in_range;

    assign full     = (count_q == FULL_CNT);
    assign pop      = bus.OutValid_40 && bus.OutReady_40;
    // A full queue still accepts a fetch when its head leaves this same cycle.
    assign slot_ok  = !full || pop;
    assign in_range = ({2'b00, pc_q[31:2]} < IMEM_LIMIT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.Redirect_40) begin
                    flush = 1'b1;
                    if (bus.RedirectTarget_40[1:0] != 2'b00) begin
                        state_d    = ST_FAULT;
                        fault_pc_d = bus.RedirectTarget_40;
                    end else begin
                        pc_d = bus.RedirectTarget_40;
                    end
                end else if (slot_ok) begin
                    if (in_range) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        state_d    = ST_FAULT;
                        fault_pc_d = pc_q;
                    end
                end
            end
            ST_FAULT: begin
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge Clk_40) begin
        if (Rst_40) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_ff @(posedge Clk_40) begin
        if (Rst_40 || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge Clk_40) begin
        if (push) begin
            q_pc_q[wr_ptr_q]  <= pc_q;
            q_ins_q[wr_ptr_q] <= bus.ImemInstruction_40;
        end
    end

    assign bus.ImemAddress_40    = pc_q;
    assign bus.OutValid_40       = (count_q != '0);
    assign bus.OutPC_40          = q_pc_q[rd_ptr_q];
    assign bus.OutInstruction_40 = q_ins_q[rd_ptr_q];
    assign bus.Fault_40          = (state_q == ST_FAULT);
    assign bus.FaultPC_40        = fault_pc_q;
    assign bus.FetchState_40     = state_q;
endmodule
